// File: rtl/stream_pkg.sv
// Shared types and constants for the randomized stream source/sink blocks.
// The Galois step lives here so every LFSR user advances identically.
package stream_pkg;

  typedef enum logic {ST_READY, ST_STALL} state_e;

  localparam logic [15:0] LFSR_MASK = 16'hB400;
  localparam int          CNT_W     = 16;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? LFSR_MASK : 16'h0000);
  endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit right-shifting Galois LFSR; advances one step per cycle with en high.
// A zero seed would lock up, so it is replaced by 1 at reset.
module lfsr16
  import stream_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  logic [15:0] q_q;
  logic [15:0] q_d;

  always_comb begin
    q_d = q_q;
    if (en) q_d = lfsr_next(q_q);
  end

  always_ff @(posedge clk) begin
    if (!rst) q_q <= (seed == 16'h0000) ? 16'h0001 : seed;
    else      q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/sink_rand.sv
// Stream sink with LFSR-driven backpressure, beat/packet statistics and a protocol monitor.
// Stats visible one cycle after the accepting edge; ready drops for d cycles after an accept.
module sink_rand
  import stream_pkg::*;
#(
  parameter int          LEN          = 8,
  parameter logic [15:0] SEED         = 16'hACE1,
  parameter bit          STALL_EN     = 1'b1,
  parameter int          MAX_DLY_BITS = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid,
  input  logic             last,
  input  logic [LEN-1:0]   data,
  output logic             ready,
  output logic [CNT_W-1:0] word_cnt,
  output logic [CNT_W-1:0] pkt_cnt,
  output logic [LEN-1:0]   checksum,
  output logic [LEN-1:0]   last_data,
  output logic             proto_err
);

  state_e                  state_q;
  logic                    ready_q;
  logic [MAX_DLY_BITS-1:0] dly_cnt_q;

  logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
  logic [CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;
  logic [LEN-1:0]   checksum_q, checksum_d;
  logic [LEN-1:0]   last_data_q, last_data_d;

  logic             stalled_q;
  logic [LEN-1:0]   data_q;
  logic             proto_err_q;

  logic                    accept;
  logic [15:0]             lfsr;
  logic [MAX_DLY_BITS-1:0] dly;
  logic                    violation;

  assign accept = valid && ready_q;
  assign dly    = lfsr[MAX_DLY_BITS-1:0];

  // Upper LFSR bits are kept only for other consumers of the same generator.
  logic unused_lfsr_hi;
  assign unused_lfsr_hi = ^lfsr[15:MAX_DLY_BITS];

  lfsr16 u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .en   (accept),
    .seed (SEED),
    .q    (lfsr)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_READY;
      ready_q   <= 1'b0;
      dly_cnt_q <= '0;
    end else begin
      case (state_q)
        ST_READY: begin
          ready_q <= 1'b1;
          if (accept && STALL_EN && (dly != '0)) begin
            state_q   <= ST_STALL;
            dly_cnt_q <= dly;
            ready_q   <= 1'b0;
          end
        end
        ST_STALL: begin
          dly_cnt_q <= dly_cnt_q - MAX_DLY_BITS'(1);
          if (dly_cnt_q == MAX_DLY_BITS'(1)) begin
            state_q <= ST_READY;
            ready_q <= 1'b1;
          end
        end
        default: state_q <= ST_READY;
      endcase
    end
  end

  always_comb begin
    word_cnt_d  = word_cnt_q;
    pkt_cnt_d   = pkt_cnt_q;
    checksum_d  = checksum_q;
    last_data_d = last_data_q;
    if (accept) begin
      word_cnt_d  = word_cnt_q + CNT_W'(1);
      pkt_cnt_d   = pkt_cnt_q + CNT_W'(last);
      checksum_d  = checksum_q + data;
      last_data_d = data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      word_cnt_q  <= '0;
      pkt_cnt_q   <= '0;
      checksum_q  <= '0;
      last_data_q <= '0;
    end else begin
      word_cnt_q  <= word_cnt_d;
      pkt_cnt_q   <= pkt_cnt_d;
      checksum_q  <= checksum_d;
      last_data_q <= last_data_d;
    end
  end

  // A producer that was refused must hold valid and data until accepted.
  assign violation = stalled_q && (!valid || (data != data_q));

  always_ff @(posedge clk) begin
    if (!rst) begin
      stalled_q   <= 1'b0;
      data_q      <= '0;
      proto_err_q <= 1'b0;
    end else begin
      stalled_q <= valid && !ready_q;
      data_q    <= data;
      if (violation) proto_err_q <= 1'b1;
    end
  end

  assign ready     = ready_q;
  assign word_cnt  = word_cnt_q;
  assign pkt_cnt   = pkt_cnt_q;
  assign checksum  = checksum_q;
  assign last_data = last_data_q;
  assign proto_err = proto_err_q;

endmodule

// File: tb/tb_sink_rand.sv
// Bench for sink_rand: a stalling instance and a no-stall instance share clock and reset.
// Accepted beats feed a statistics/stall-length scoreboard built from a reference LFSR.
module tb_sink_rand;

  localparam logic [15:0] SEED = 16'hACE1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, valid, last;
  logic [7:0]  data;
  logic        ready, proto_err;
  logic [15:0] word_cnt, pkt_cnt;
  logic [7:0]  checksum, last_data;

  logic        v2, l2;
  logic [7:0]  d2;
  logic        ready2, perr2;
  logic [15:0] wc2, pc2;
  logic [7:0]  cs2, ld2;

  sink_rand #(.LEN(8), .SEED(SEED), .STALL_EN(1'b1), .MAX_DLY_BITS(3)) u_dut (
    .clk(clk), .rst(rst), .valid(valid), .last(last), .data(data),
    .ready(ready), .word_cnt(word_cnt), .pkt_cnt(pkt_cnt),
    .checksum(checksum), .last_data(last_data), .proto_err(proto_err)
  );

  sink_rand #(.LEN(8), .SEED(SEED), .STALL_EN(1'b0), .MAX_DLY_BITS(3)) u_nostall (
    .clk(clk), .rst(rst), .valid(v2), .last(l2), .data(d2),
    .ready(ready2), .word_cnt(wc2), .pkt_cnt(pc2),
    .checksum(cs2), .last_data(ld2), .proto_err(perr2)
  );

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [15:0] wc;
    logic [15:0] pc;
    logic [7:0]  cs;
    logic [7:0]  ld;
  } stats_t;

  stats_t      sb_q[$];
  int          stall_q[$];
  logic [15:0] m_wc, m_pc, m_lfsr;
  logic [7:0]  m_cs, m_ld;

  function automatic logic [15:0] model_next(input logic [15:0] s);
    logic        fb;
    logic [15:0] r;
    fb = s[0];
    r  = s >> 1;
    if (fb) r = r ^ 16'hB400;
    return r;
  endfunction

  task automatic model_reset();
    m_wc = 0; m_pc = 0; m_cs = 0; m_ld = 0; m_lfsr = SEED;
    sb_q.delete();
    stall_q.delete();
  endtask

  // One clock on the stalling instance; scores any beat accepted at this edge.
  task automatic step(output logic acc);
    stats_t exp_s, got_s;
    acc = rst && valid && (ready === 1'b1);
    if (acc) begin
      m_wc = m_wc + 16'd1;
      if (last) m_pc = m_pc + 16'd1;
      m_cs = m_cs + data;
      m_ld = data;
      stall_q.push_back(int'(m_lfsr[2:0]));
      m_lfsr = model_next(m_lfsr);
      sb_q.push_back(stats_t'({m_wc, m_pc, m_cs, m_ld}));
    end
    @(posedge clk); #1;
    if (acc) begin
      exp_s = sb_q.pop_front();
      got_s = stats_t'({word_cnt, pkt_cnt, checksum, last_data});
      checks++;
      if (got_s !== exp_s) begin
        errors++;
        $display("FAIL stats: got %h expected %h", got_s, exp_s);
      end
    end
  endtask

  // Hold valid until a beat is taken, then present the next payload immediately.
  task automatic wait_accept(input logic [7:0] nd, output int d);
    logic a;
    int   g;
    a = 1'b0; g = 0; valid = 1'b1;
    while (!a && g < 50) begin
      step(a);
      g++;
    end
    checks++;
    if (!a) begin
      errors++;
      $display("FAIL accept_timeout: no accept in %0d cycles, required within 50", g);
    end
    data = nd;
    last = 1'($urandom_range(0, 1));
    if (stall_q.size() > 0) d = stall_q.pop_front();
    else d = -1;
  endtask

  task automatic accept_one(input logic [7:0] nd, input bit measure);
    int   d, run;
    logic a;
    wait_accept(nd, d);
    run = 0;
    while (ready !== 1'b1 && run < 20) begin
      step(a);
      run++;
    end
    if (measure) begin
      checks++;
      if (run != d) begin
        errors++;
        $display("FAIL stall_len: ready low %0d cycles, expected %0d", run, d);
      end
    end
  endtask

  // Ends a stream cleanly: valid drops only right after an accept.
  task automatic finish_stream();
    int   d, g;
    logic a;
    wait_accept(8'h00, d);
    valid = 1'b0; last = 1'b0;
    g = 0;
    while (ready !== 1'b1 && g < 20) begin
      step(a);
      g++;
    end
  endtask

  task automatic do_reset();
    rst = 1'b0; valid = 1'b0; last = 1'b0;
    model_reset();
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({ready, proto_err} !== 2'b10) begin
      errors++;
      $display("FAIL reset_release: ready/proto_err %b expected 10", {ready, proto_err});
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; valid = 1'b1; last = 1'b1; data = 8'h33;
    v2 = 1'b0; l2 = 1'b0; d2 = 8'h00;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({ready, word_cnt, pkt_cnt, checksum, last_data, proto_err} !== 50'd0) begin
        errors++;
        $display("FAIL reset_hold: outputs %h expected 0",
                 {ready, word_cnt, pkt_cnt, checksum, last_data, proto_err});
      end
    end
    rst = 1'b1; valid = 1'b0; last = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({ready, ready2} !== 2'b11) begin
      errors++;
      $display("FAIL ready_after_reset: ready %b/%b expected 1/1", ready, ready2);
    end
    checks++;
    if ({word_cnt, proto_err} !== 17'd0) begin
      errors++;
      $display("FAIL no_accept_in_reset: word_cnt %0d proto_err %b expected 0/0", word_cnt, proto_err);
    end
  endtask

  task automatic test_single_beat();
    logic a;
    int   d, run;
    data = 8'h5A; last = 1'b1; valid = 1'b1;
    step(a);
    valid = 1'b0; last = 1'b0;
    checks++;
    if ({a, word_cnt, pkt_cnt, checksum, last_data} !== {1'b1, 16'd1, 16'd1, 8'h5A, 8'h5A}) begin
      errors++;
      $display("FAIL single_beat: acc %b wc %0d pc %0d cs %h ld %h expected 1 1 1 5a 5a",
               a, word_cnt, pkt_cnt, checksum, last_data);
    end
    d = (stall_q.size() > 0) ? stall_q.pop_front() : -1;
    run = 0;
    while (ready !== 1'b1 && run < 20) begin
      step(a);
      run++;
    end
    checks++;
    if (run != d) begin
      errors++;
      $display("FAIL single_stall: ready low %0d cycles, expected %0d", run, d);
    end
  endtask

  task automatic test_throughput();
    int n_acc;
    n_acc = 0;
    v2 = 1'b1; d2 = 8'hFF;
    for (int i = 0; i < 300; i++) begin
      l2 = ((i % 10) == 9);
      if (ready2 === 1'b1) n_acc++;
      @(posedge clk); #1;
    end
    v2 = 1'b0; l2 = 1'b0;
    checks++;
    if (n_acc != 300) begin
      errors++;
      $display("FAIL tput_accepts: %0d accepts in 300 cycles, expected 300", n_acc);
    end
    checks++;
    if ({wc2, pc2, cs2, ld2, perr2} !== {16'd300, 16'd30, 8'hD4, 8'hFF, 1'b0}) begin
      errors++;
      $display("FAIL tput_stats: wc %0d pc %0d cs %h ld %h err %b expected 300 30 d4 ff 0",
               wc2, pc2, cs2, ld2, perr2);
    end
  endtask

  task automatic test_backpressure();
    data = 8'($urandom); last = 1'b0; valid = 1'b1;
    for (int i = 0; i < 50; i++) accept_one(8'($urandom), 1'b1);
    finish_stream();
    checks++;
    if (proto_err !== 1'b0) begin
      errors++;
      $display("FAIL bp_proto_err: proto_err %b expected 0", proto_err);
    end
  endtask

  task automatic test_violation_data();
    logic a;
    int   d, g;
    valid = 1'b1; data = 8'h10; g = 0;
    while (m_lfsr[2:0] == 3'd0 && g < 100) begin
      accept_one(8'h10, 1'b1);
      g++;
    end
    wait_accept(8'h10, d);
    step(a);
    data = 8'h11;
    step(a);
    checks++;
    if (proto_err !== 1'b1) begin
      errors++;
      $display("FAIL viol_data: proto_err %b expected 1", proto_err);
    end
    valid = 1'b0;
    repeat (10) step(a);
    checks++;
    if (proto_err !== 1'b1) begin
      errors++;
      $display("FAIL viol_sticky: proto_err %b expected 1", proto_err);
    end
  endtask

  task automatic test_violation_valid();
    logic a;
    int   d, g;
    do_reset();
    valid = 1'b1; data = 8'h20; g = 0;
    while (m_lfsr[2:0] == 3'd0 && g < 100) begin
      accept_one(8'h20, 1'b1);
      g++;
    end
    wait_accept(8'h20, d);
    step(a);
    valid = 1'b0;
    step(a);
    checks++;
    if (proto_err !== 1'b1) begin
      errors++;
      $display("FAIL viol_valid: proto_err %b expected 1", proto_err);
    end
    checks++;
    if (word_cnt !== m_wc) begin
      errors++;
      $display("FAIL viol_no_accept: word_cnt %0d expected %0d", word_cnt, m_wc);
    end
  endtask

  task automatic test_reset_mid_stall();
    logic a;
    int   d, g;
    do_reset();
    valid = 1'b1; data = 8'($urandom); g = 0;
    while (m_lfsr[2:0] != 3'd5 && g < 200) begin
      accept_one(8'($urandom), 1'b1);
      g++;
    end
    wait_accept(8'($urandom), d);
    step(a);
    step(a);
    checks++;
    if (ready !== 1'b0) begin
      errors++;
      $display("FAIL midstall_ready: ready %b expected 0 (stall %0d)", ready, d);
    end
    rst = 1'b0; valid = 1'b0; last = 1'b0;
    @(posedge clk); #1;
    model_reset();
    checks++;
    if ({ready, word_cnt, pkt_cnt, checksum, last_data} !== 49'd0) begin
      errors++;
      $display("FAIL midstall_reset: outputs %h expected 0",
               {ready, word_cnt, pkt_cnt, checksum, last_data});
    end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("FAIL midstall_release: ready %b expected 1", ready);
    end
    valid = 1'b1;
    for (int i = 0; i < 6; i++) accept_one(8'($urandom), 1'b1);
    finish_stream();
  endtask

  initial begin
    test_reset();
    test_single_beat();
    test_throughput();
    test_backpressure();
    test_violation_data();
    test_violation_valid();
    test_reset_mid_stall();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sink_rand.md
# sink_rand

Stream consumer for the valid/ready/last handshake driven by `source_rand`-style producers. It asserts `ready` with pseudo-random backpressure from an internal LFSR, accepts beats, and tracks word count, packet count, a running modular checksum and the last accepted word. It also flags handshake violations by the producer. It sits at the downstream end of the test stream path and serves as the bench's traffic sink and protocol monitor.

## Interface
- `LEN`, 8, data width in bits
- `SEED`, 16'hACE1, LFSR reset value; 0 is replaced by 16'h0001
- `STALL_EN`, 1, 1 = random backpressure; 0 = `ready` held high outside reset
- `MAX_DLY_BITS`, 3, number of LFSR bits used as the stall length (0..2^MAX_DLY_BITS-1 cycles)

Ports:
- `clk`  input  1  clock; all logic on rising edge
- `rst`  input  1  synchronous, active-low reset (0 = reset)
- `valid`  input  1  producer has a beat
- `last`  input  1  beat ends a packet
- `data`  input  LEN  beat payload
- `ready`  output  1  registered; sink accepts this cycle
- `word_cnt`  output  16  accepted beats, wraps
- `pkt_cnt`  output  16  accepted beats with `last`=1, wraps
- `checksum`  output  LEN  sum of accepted `data` mod 2^LEN
- `last_data`  output  LEN  most recent accepted `data`
- `proto_err`  output  1  sticky producer-violation flag

## Operation
- Accept = `valid && ready` at a rising edge. Each accept: `word_cnt`+1, `checksum` += `data` (truncated to LEN), `last_data` <= `data`, `pkt_cnt`+1 if `last`.
- FSM states:
  - READY: `ready`=1.
  - STALL: `ready`=0, `dly_cnt` counts down.
- READY, on accept: d = `lfsr[MAX_DLY_BITS-1:0]`.
  - If `STALL_EN`=0 or d=0, stay in READY.
  - Otherwise go to STALL and load `dly_cnt`=d.
- STALL: decrement each cycle. When `dly_cnt`=1, the next state is READY.
- LFSR: 16-bit Galois, mask 16'hB400, shifts right. It advances exactly once per accept, using the value sampled before the advance, so the stall sequence depends only on the accept count.
- Protocol monitor: `stalled_q` <= `valid && !ready`, and `data_q` <= `data`. If `stalled_q`=1, then in the current cycle `valid`=0 or `data`!=`data_q` sets `proto_err`=1. `proto_err` clears only on reset.
- `valid` without `ready` is legal. `last` is only meaningful on accept.

## Timing
- During reset: `ready`=0, FSM=READY, LFSR=SEED, all counters, `checksum`, `last_data` and `proto_err` are 0.
- First cycle after `rst` goes high: `ready`=1.
- Counter and status outputs update on the edge that accepts; they are visible the next cycle (latency 1).
- Accept with stall d>0: `ready` is 0 for exactly d cycles, starting the cycle after the accept, then returns to 1.
- Back-to-back: with d=0, beats can be accepted every cycle.
- Counters wrap 16'hFFFF -> 0 with no flag. `checksum` wraps silently.
- Reset asserted mid-STALL: the next cycle has `ready`=0 and state READY, and the LFSR reloads SEED. Any stall in progress is abandoned.
- An error that coincides with an accept still sets `proto_err`. The accept is counted normally.

## Structure
- Package `stream_pkg`:
  - state enum {ST_READY, ST_STALL}
  - `LFSR_MASK` = 16'hB400
  - `CNT_W` = 16
- Sub-module `lfsr16` (ports: `clk`, `rst`, `en`, `seed`, `q`). It is shared with future randomized sources.
- Top level holds the FSM, delay counter, statistics registers and protocol monitor.

## Test plan
- Reset: hold `rst`=0 for 3 cycles with `valid`=1.
  - During reset: `ready`=0, all outputs 0, no accept.
  - Cycle after release: `ready`=1.
- Single beat: `data`=8'h5A, `last`=1, `valid`=1 for one accept.
  - Next cycle: `word_cnt`=1, `pkt_cnt`=1, `checksum`=8'h5A, `last_data`=8'h5A.
- Throughput: `STALL_EN`=0, 300 consecutive beats of 8'hFF, `last` on every 10th.
  - Accepted in 300 cycles; `word_cnt`=300, `pkt_cnt`=30, `checksum`=8'hD4.
- Backpressure: `STALL_EN`=1, SEED=16'hACE1, `valid` held high for 50 accepts.
  - Each `ready`-low run length matches a bench LFSR model's `lfsr[2:0]` value at that accept.
  - `proto_err`=0.
- Violations:
  - During STALL, change `data` 8'h10 -> 8'h11 while `valid`=1: `proto_err`=1 and stays high.
  - After reset, during STALL, drop `valid` with no accept: `proto_err`=1.
- Reset mid-stall: assert `rst`=0 during a stall of d=5.
  - Next cycle: `ready`=0, counters 0.
  - After release: `ready`=1, and the stall sequence restarts from SEED.
